ewrapper_emesh_tx_arbiter: RTL

//  Shares the elink outbound emesh port (emesh_*_outb into the link transmitter) between two requesters,
//  e.g. the AXI-slave write/read path and the AXI-master read-response path. Round-robin fairness;

---
 rtl/ewrapper_emesh_tx_arbiter_pkg.sv | 35 +++
 rtl/ewrapper_burst_chk.sv | 28 ++
 rtl/ewrapper_emesh_tx_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/ewrapper_emesh_tx_arbiter_pkg.sv
// ewrapper_emesh_tx_arbiter_pkg
//   Shared definitions for the emesh outbound arbiter. It holds the emesh packet
//   field widths, the double-word datamode code, the burst address stride, the
//   arbiter state type and the packet struct used to carry a request's payload.
//   There are no ports.
package ewrapper_emesh_tx_arbiter_pkg;

  localparam int AW  = 32;  // address width (dstaddr / srcaddr)
  localparam int DW  = 32;  // data width
  localparam int DMW = 2;   // datamode width
  localparam int CMW = 4;   // ctrlmode width

  localparam logic [DMW-1:0] DM_DOUBLE    = 2'b11;
  localparam logic [AW-1:0]  BURST_STRIDE = 32'd8;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic           write;
    logic [DMW-1:0] datamode;
    logic [CMW-1:0] ctrlmode;
    logic [AW-1:0]  dstaddr;
    logic [AW-1:0]  srcaddr;
    logic [DW-1:0]  data;
  } emesh_pkt_t;

  // A double-word write is the only kind of transaction that can start or extend a burst.
  function automatic logic is_double_write(input emesh_pkt_t p);
    return p.write && (p.datamode == DM_DOUBLE);
  endfunction

endpackage

// File: rtl/ewrapper_burst_chk.sv
// ewrapper_burst_chk
//   Purely combinational check that decides whether a candidate transaction
//   continues the current burst. It must be a double-word write whose
//   destination is exactly one stride past the previous beat. The address
//   addition wraps at 32 bits.
// Ports
//   i_prev_dstaddr   [31:0] in   dstaddr of the previously granted beat
//   i_cand_dstaddr   [31:0] in   dstaddr of the candidate beat
//   i_cand_write            in   candidate is a write
//   i_cand_datamode  [1:0]  in   candidate datamode
//   o_contiguous            out  candidate extends the burst
module ewrapper_burst_chk
  import ewrapper_emesh_tx_arbiter_pkg::*;
(
  input  logic [AW-1:0]  i_prev_dstaddr,
  input  logic [AW-1:0]  i_cand_dstaddr,
  input  logic           i_cand_write,
  input  logic [DMW-1:0] i_cand_datamode,
  output logic           o_contiguous
);

  logic [AW-1:0] w_next_addr;

  assign w_next_addr  = i_prev_dstaddr + BURST_STRIDE;
  assign o_contiguous = i_cand_write && (i_cand_datamode == DM_DOUBLE) &&
                        (i_cand_dstaddr == w_next_addr);

endmodule

// File: rtl/ewrapper_emesh_tx_arbiter.sv
// ewrapper_emesh_tx_arbiter
//   Shares the elink outbound emesh port between two requesters. Arbitration is
//   round-robin. Link write and read backpressure are honoured per request type.
//   When i_burst_en is set, the grant can lock onto one owner for a run of
//   contiguous double-word writes, so the transmitter can burst them.
//   Accepted transactions appear on the registered o_emesh_* outputs one cycle
//   later.
// Ports
//   i_emesh_clk_inb                 in   single clock
//   i_reset                         in   synchronous, active-high
//   i_burst_en                      in   enables burst lock
//   i_reqN_access/write/datamode/
//     ctrlmode/dstaddr/srcaddr/data in   requester N transaction (held until accepted)
//   o_reqN_wait                     out  requester N not accepted this cycle
//   i_emesh_wr_wait_inb             in   link write backpressure
//   i_emesh_rd_wait_inb             in   link read backpressure
//   o_emesh_access_outb             out  one-cycle valid per transaction
//   o_emesh_write/datamode/ctrlmode/
//     dstaddr/srcaddr/data_outb     out  registered payload, held between transactions
//
// state   | meaning
// ST_ARB  | round-robin between eligible requesters
// ST_LOCK | grant reserved for the burst owner while it keeps issuing contiguous doubles
module ewrapper_emesh_tx_arbiter
  import ewrapper_emesh_tx_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 8,
  parameter int BCW       = 3
) (
  input  logic           i_emesh_clk_inb,
  input  logic           i_reset,
  input  logic           i_burst_en,

  input  logic           i_req0_access,
  input  logic           i_req0_write,
  input  logic [DMW-1:0] i_req0_datamode,
  input  logic [CMW-1:0] i_req0_ctrlmode,
  input  logic [AW-1:0]  i_req0_dstaddr,
  input  logic [AW-1:0]  i_req0_srcaddr,
  input  logic [DW-1:0]  i_req0_data,
  output logic           o_req0_wait,

  input  logic           i_req1_access,
  input  logic           i_req1_write,
  input  logic [DMW-1:0] i_req1_datamode,
  input  logic [CMW-1:0] i_req1_ctrlmode,
  input  logic [AW-1:0]  i_req1_dstaddr,
  input  logic [AW-1:0]  i_req1_srcaddr,
  input  logic [DW-1:0]  i_req1_data,
  output logic           o_req1_wait,

  input  logic           i_emesh_wr_wait_inb,
  input  logic           i_emesh_rd_wait_inb,

  output logic           o_emesh_access_outb,
  output logic           o_emesh_write_outb,
  output logic [DMW-1:0] o_emesh_datamode_outb,
  output logic [CMW-1:0] o_emesh_ctrlmode_outb,
  output logic [AW-1:0]  o_emesh_dstaddr_outb,
  output logic [AW-1:0]  o_emesh_srcaddr_outb,
  output logic [DW-1:0]  o_emesh_data_outb
);

  // The lock holds for the first beat plus this many more beats.
  localparam logic [BCW-1:0] BEATS_AFTER_FIRST = BCW'(MAX_BURST - 1);

  arb_state_t     r_state, w_state_nxt;
  // While locked, the owner is always the most recent grantee, so last_grant
  // also serves as the owner id.
  logic           r_last_grant, w_last_grant_nxt;
  logic [BCW-1:0] r_beats_left, w_beats_left_nxt;
  logic           r_access;
  emesh_pkt_t     r_out;

  emesh_pkt_t     w_pkt0, w_pkt1, w_owner_pkt, w_rr_pkt, w_grant_pkt;
  logic           w_elig0, w_elig1, w_owner_elig;
  logic           w_contig, w_lock_hold, w_rr_sel;
  logic           w_grant0, w_grant1;

  assign w_pkt0 = {i_req0_write, i_req0_datamode, i_req0_ctrlmode,
                   i_req0_dstaddr, i_req0_srcaddr, i_req0_data};
  assign w_pkt1 = {i_req1_write, i_req1_datamode, i_req1_ctrlmode,
                   i_req1_dstaddr, i_req1_srcaddr, i_req1_data};

  assign w_elig0 = i_req0_access &
                   (i_req0_write ? ~i_emesh_wr_wait_inb : ~i_emesh_rd_wait_inb);
  assign w_elig1 = i_req1_access &
                   (i_req1_write ? ~i_emesh_wr_wait_inb : ~i_emesh_rd_wait_inb);

  assign w_owner_pkt  = r_last_grant ? w_pkt1 : w_pkt0;
  assign w_owner_elig = r_last_grant ? w_elig1 : w_elig0;

  // The previous beat's dstaddr is the one still held in the output register.
  ewrapper_burst_chk u_burst_chk (
    .i_prev_dstaddr  (r_out.dstaddr),
    .i_cand_dstaddr  (w_owner_pkt.dstaddr),
    .i_cand_write    (w_owner_pkt.write),
    .i_cand_datamode (w_owner_pkt.datamode),
    .o_contiguous    (w_contig)
  );

  assign w_lock_hold = (r_state == ST_LOCK) && i_burst_en && w_owner_elig &&
                       w_contig && (r_beats_left != '0);

  // Select req1 when it is the only eligible requester, or when both are eligible and req0 went last.
  assign w_rr_sel = w_elig1 & (~w_elig0 | ~r_last_grant);
  assign w_rr_pkt = w_rr_sel ? w_pkt1 : w_pkt0;

  always_comb begin
    w_grant0         = 1'b0;
    w_grant1         = 1'b0;
    w_state_nxt      = ST_ARB;
    w_last_grant_nxt = r_last_grant;
    w_beats_left_nxt = r_beats_left;
    if (w_lock_hold) begin
      w_grant0         = ~r_last_grant;
      w_grant1         = r_last_grant;
      w_beats_left_nxt = r_beats_left - BCW'(1);
      w_state_nxt      = ST_LOCK;
    end else if (w_elig0 | w_elig1) begin
      // A failed lock also falls through to here in the same cycle. The owner
      // is last_grant, so the other requester wins the tie.
      w_grant0         = ~w_rr_sel;
      w_grant1         = w_rr_sel;
      w_last_grant_nxt = w_rr_sel;
      if (i_burst_en && (MAX_BURST > 1) && is_double_write(w_rr_pkt)) begin
        w_state_nxt      = ST_LOCK;
        w_beats_left_nxt = BEATS_AFTER_FIRST;
      end
    end
  end

  always_ff @(posedge i_emesh_clk_inb) begin
    if (i_reset) begin
      r_state      <= ST_ARB;
      r_last_grant <= 1'b1;
      r_beats_left <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_beats_left <= w_beats_left_nxt;
    end
  end

  assign w_grant_pkt = w_grant1 ? w_pkt1 : w_pkt0;

  always_ff @(posedge i_emesh_clk_inb) begin
    if (i_reset) begin
      r_access <= 1'b0;
      r_out    <= '0;
    end else begin
      r_access <= w_grant0 | w_grant1;
      if (w_grant0 | w_grant1) begin
        r_out <= w_grant_pkt;
      end
    end
  end

  assign o_req0_wait = i_req0_access & ~w_grant0;
  assign o_req1_wait = i_req1_access & ~w_grant1;

  assign o_emesh_access_outb   = r_access;
  assign o_emesh_write_outb    = r_out.write;
  assign o_emesh_datamode_outb = r_out.datamode;
  assign o_emesh_ctrlmode_outb = r_out.ctrlmode;
  assign o_emesh_dstaddr_outb  = r_out.dstaddr;
  assign o_emesh_srcaddr_outb  = r_out.srcaddr;
  assign o_emesh_data_outb     = r_out.data;

endmodule
